apb_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single request port of the APB master between up to eight requesters (CPU data port, DMA, debug). It sits between the requesters and the APB master's request side. It latches the winning request, holds it on the downstream port until completion, and returns the registered response to the winner only. One transfer is outstanding at a time; there is no pipelining across requesters.

---
 rtl/apb_arb_pkg.sv | 15 +
 rtl/apb_req_arbiter_if.sv | 51 +++++
 rtl/rr_arbiter_core.sv | 50 +++++
 rtl/apb_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB request arbiter.
//   IDLE/BUSY/DONE : arbiter FSM state encoding
//   gnt_w()        : width of an encoded grant index (at least 1 bit)
package apb_arb_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // A single requester still needs a 1-bit index so grant_id is never zero-width.
  function automatic int unsigned gnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side and APB-master-side signals around the arbiter.
//   m_*      : requester handshake (valid/write/addr/wdata in, ready/rdata/error out)
//   req_*    : request port towards the APB master and its completion response
//   grant_id : debug view of the current or last winner
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus APB master)
interface apb_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  import apb_arb_pkg::*;

  localparam int unsigned GNT_W = gnt_w(NUM_REQ);

  logic [NUM_REQ-1:0]        m_valid;
  logic [NUM_REQ-1:0]        m_write;
  logic [NUM_REQ*ADDR_W-1:0] m_addr;
  logic [NUM_REQ*DATA_W-1:0] m_wdata;
  logic [NUM_REQ-1:0]        m_ready;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_error;

  logic                      req_valid;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic                      req_ready;
  logic [DATA_W-1:0]         req_rdata;
  logic                      req_error;

  logic [GNT_W-1:0]          grant_id;

  modport slave (
    input  m_valid, m_write, m_addr, m_wdata,
    output m_ready, m_rdata, m_error,
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, req_rdata, req_error,
    output grant_id
  );

  modport master (
    output m_valid, m_write, m_addr, m_wdata,
    input  m_ready, m_rdata, m_error,
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, req_rdata, req_error,
    input  grant_id
  );

endinterface

// File: rtl/rr_arbiter_core.sv
// Combinational rotating-priority selector.
//   i_req  : request vector
//   i_last : index of the previous winner; search starts at i_last+1 mod NUM_REQ
//   o_gnt  : one-hot grant (zero when no request)
//   o_idx  : encoded grant index (zero when no request)
//   o_any  : at least one request is present
module rr_arbiter_core #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic        w_found;
  logic        w_hit;
  int unsigned w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_any   = |i_req;
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_cand  = 0;
    // Offset NUM_REQ wraps back to the last winner, so it has the lowest priority.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = (32'(i_last) + k) % NUM_REQ;
      w_hit  = 1'b0;
      for (int unsigned c = 0; c < NUM_REQ; c++) begin
        if (c == w_cand) begin
          w_hit = i_req[c];
        end
      end
      if (!w_found && w_hit) begin
        w_found = 1'b1;
        o_idx   = IDX_W'(w_cand);
        for (int unsigned c = 0; c < NUM_REQ; c++) begin
          if (c == w_cand) begin
            o_gnt[c] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master request port among NUM_REQ requesters.
// One transfer is outstanding at a time: the winner's request is latched in IDLE,
// presented downstream during BUSY, and the registered response is returned to
// the winner alone as a one-cycle m_ready pulse in DONE.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : requester and APB-master signals (slave modport)
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input logic              clk,
  input logic              rst,
  apb_req_arbiter_if.slave bus
);

  localparam int unsigned GNT_W = gnt_w(NUM_REQ);

  logic [1:0]         r_state,      w_state_nxt;
  logic [GNT_W-1:0]   r_last_grant, w_last_grant_nxt;
  logic [GNT_W-1:0]   r_grant_id,   w_grant_id_nxt;
  logic [NUM_REQ-1:0] r_gnt_oh,     w_gnt_oh_nxt;
  logic               r_req_valid,  w_req_valid_nxt;
  logic               r_write,      w_write_nxt;
  logic [ADDR_W-1:0]  r_addr,       w_addr_nxt;
  logic [DATA_W-1:0]  r_wdata,      w_wdata_nxt;
  logic [NUM_REQ-1:0] r_m_ready,    w_m_ready_nxt;
  logic [DATA_W-1:0]  r_rdata,      w_rdata_nxt;
  logic               r_error,      w_error_nxt;

  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [GNT_W-1:0]   w_gnt_idx;
  logic               w_any;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GNT_W)
  ) u_rr_core (
    .i_req  (bus.m_valid),
    .i_last (r_last_grant),
    .o_gnt  (w_gnt_oh),
    .o_idx  (w_gnt_idx),
    .o_any  (w_any)
  );

  // Mux the winner's fields out of the flattened request buses.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_write = bus.m_write[i];
        w_sel_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_id_nxt   = r_grant_id;
    w_gnt_oh_nxt     = r_gnt_oh;
    w_req_valid_nxt  = r_req_valid;
    w_write_nxt      = r_write;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_m_ready_nxt    = '0;
    w_rdata_nxt      = r_rdata;
    w_error_nxt      = r_error;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt      = BUSY;
          w_last_grant_nxt = w_gnt_idx;
          w_grant_id_nxt   = w_gnt_idx;
          w_gnt_oh_nxt     = w_gnt_oh;
          w_write_nxt      = w_sel_write;
          w_addr_nxt       = w_sel_addr;
          w_wdata_nxt      = w_sel_wdata;
          w_req_valid_nxt  = 1'b1;
        end
      end
      BUSY: begin
        // m_valid is deliberately not looked at here: a dropped request still completes.
        if (bus.req_ready) begin
          w_state_nxt     = DONE;
          w_req_valid_nxt = 1'b0;
          w_rdata_nxt     = bus.req_rdata;
          w_error_nxt     = bus.req_error;
          w_m_ready_nxt   = r_gnt_oh;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_req_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_gnt_oh     <= '0;
      r_req_valid  <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_m_ready    <= '0;
      r_rdata      <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_gnt_oh     <= w_gnt_oh_nxt;
      r_req_valid  <= w_req_valid_nxt;
      r_write      <= w_write_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_m_ready    <= w_m_ready_nxt;
      r_rdata      <= w_rdata_nxt;
      r_error      <= w_error_nxt;
    end
  end

  assign bus.req_valid = r_req_valid;
  assign bus.req_write = r_write;
  assign bus.req_addr  = r_addr;
  assign bus.req_wdata = r_wdata;
  assign bus.m_ready   = r_m_ready;
  assign bus.m_rdata   = r_rdata;
  assign bus.m_error   = r_error;
  assign bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a 2-requester and a 4-requester instance
// share clock and reset; inputs change and outputs are sampled on falling edges.
module tb_apb_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  apb_req_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus2 ();
  apb_req_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) bus4 ();

  apb_req_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  apb_req_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer on the 4-requester instance with a zero-wait downstream.
  task automatic xfer4(input logic [3:0] vld, input int unsigned id);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    bus4.m_valid = vld;
    @(negedge clk);
    check("c_req_valid", 64'(bus4.req_valid), 64'd1);
    check("c_grant_id", 64'(bus4.grant_id), 64'(id));
    check("c_req_addr", 64'(bus4.req_addr), 64'((id + 1) * 32'h100));
    @(negedge clk);
    check("c_m_ready", 64'(bus4.m_ready), 64'(oh));
    check("c_m_rdata", 64'(bus4.m_rdata), 64'h0000_0000_CAFE_0000);
    check("c_done_req_valid", 64'(bus4.req_valid), 64'd0);
    @(negedge clk);
    check("c_idle_m_ready", 64'(bus4.m_ready), 64'd0);
    check("c_idle_req_valid", 64'(bus4.req_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus2.m_valid = '0; bus2.m_write = '0; bus2.m_addr = '0; bus2.m_wdata = '0;
    bus2.req_ready = 1'b0; bus2.req_rdata = '0; bus2.req_error = 1'b0;
    bus4.m_valid = '0; bus4.m_write = '0; bus4.m_addr = '0; bus4.m_wdata = '0;
    bus4.req_ready = 1'b1; bus4.req_rdata = 32'hCAFE_0000; bus4.req_error = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus4.m_addr[i*32 +: 32] = (i + 1) * 32'h100;
    end

    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(bus2.req_valid), 64'd0);
    check("rst_req_write", 64'(bus2.req_write), 64'd0);
    check("rst_req_addr", 64'(bus2.req_addr), 64'd0);
    check("rst_req_wdata", 64'(bus2.req_wdata), 64'd0);
    check("rst_m_ready", 64'(bus2.m_ready), 64'd0);
    check("rst_m_rdata", 64'(bus2.m_rdata), 64'd0);
    check("rst_m_error", 64'(bus2.m_error), 64'd0);
    check("rst_grant_id", 64'(bus2.grant_id), 64'd0);
    check("rst_grant_id4", 64'(bus4.grant_id), 64'd0);

    // Single-requester write held for two BUSY cycles.
    rst = 1'b0;
    bus2.m_valid = 2'b01;
    bus2.m_write = 2'b01;
    bus2.m_addr[31:0] = 32'h1000_0004;
    bus2.m_wdata[31:0] = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("w_req_valid", 64'(bus2.req_valid), 64'd1);
      check("w_req_write", 64'(bus2.req_write), 64'd1);
      check("w_req_addr", 64'(bus2.req_addr), 64'h1000_0004);
      check("w_req_wdata", 64'(bus2.req_wdata), 64'hDEAD_BEEF);
      check("w_grant_id", 64'(bus2.grant_id), 64'd0);
      check("w_busy_m_ready", 64'(bus2.m_ready), 64'd0);
      if (c == 1) begin
        bus2.req_ready = 1'b1;
        bus2.req_rdata = 32'h5555_AAAA;
        bus2.req_error = 1'b0;
      end
    end
    @(negedge clk);
    bus2.req_ready = 1'b0;
    check("w_m_ready", 64'(bus2.m_ready), 64'd1);
    check("w_m_error", 64'(bus2.m_error), 64'd0);
    check("w_done_req_valid", 64'(bus2.req_valid), 64'd0);
    bus2.m_valid = 2'b00;
    @(negedge clk);
    check("w_idle_m_ready", 64'(bus2.m_ready), 64'd0);

    // Read from requester 1 returning a slave error.
    bus2.m_valid = 2'b10;
    bus2.m_write = 2'b00;
    bus2.m_addr[63:32] = 32'h2000_0000;
    @(negedge clk);
    check("r_req_valid", 64'(bus2.req_valid), 64'd1);
    check("r_req_write", 64'(bus2.req_write), 64'd0);
    check("r_req_addr", 64'(bus2.req_addr), 64'h2000_0000);
    check("r_grant_id", 64'(bus2.grant_id), 64'd1);
    bus2.req_ready = 1'b1;
    bus2.req_rdata = 32'h1234_5678;
    bus2.req_error = 1'b1;
    @(negedge clk);
    bus2.req_ready = 1'b0;
    bus2.req_error = 1'b0;
    check("r_m_ready", 64'(bus2.m_ready), 64'd2);
    check("r_m_rdata", 64'(bus2.m_rdata), 64'h1234_5678);
    check("r_m_error", 64'(bus2.m_error), 64'd1);
    bus2.m_valid = 2'b00;
    @(negedge clk);
    check("r_idle_m_ready", 64'(bus2.m_ready), 64'd0);

    // Back-to-back transfers from requester 0; req_valid low for exactly DONE and IDLE.
    bus2.m_valid = 2'b01;
    bus2.m_write = 2'b01;
    bus2.m_addr[31:0] = 32'h1000_0010;
    bus2.m_wdata[31:0] = 32'h0000_1111;
    @(negedge clk);
    check("b1_req_valid", 64'(bus2.req_valid), 64'd1);
    check("b1_req_addr", 64'(bus2.req_addr), 64'h1000_0010);
    bus2.req_ready = 1'b1;
    @(negedge clk);
    bus2.req_ready = 1'b0;
    check("b1_m_ready", 64'(bus2.m_ready), 64'd1);
    check("b_gap1_req_valid", 64'(bus2.req_valid), 64'd0);
    bus2.m_addr[31:0] = 32'h1000_0020;
    bus2.m_wdata[31:0] = 32'h0000_2222;
    @(negedge clk);
    check("b_gap2_req_valid", 64'(bus2.req_valid), 64'd0);
    check("b_gap2_m_ready", 64'(bus2.m_ready), 64'd0);
    @(negedge clk);
    check("b2_req_valid", 64'(bus2.req_valid), 64'd1);
    check("b2_req_addr", 64'(bus2.req_addr), 64'h1000_0020);
    check("b2_req_wdata", 64'(bus2.req_wdata), 64'h0000_2222);
    bus2.req_ready = 1'b1;
    @(negedge clk);
    bus2.req_ready = 1'b0;
    bus2.m_valid = 2'b00;
    check("b2_m_ready", 64'(bus2.m_ready), 64'd1);
    @(negedge clk);

    // Reset while BUSY: outputs clear at once, requester 0 wins first afterwards.
    bus2.m_valid = 2'b01;
    bus2.m_addr[31:0] = 32'h3000_0000;
    @(negedge clk);
    check("x_req_valid", 64'(bus2.req_valid), 64'd1);
    check("x_req_addr", 64'(bus2.req_addr), 64'h3000_0000);
    #2 rst = 1'b1;
    #1;
    check("x_rst_req_valid", 64'(bus2.req_valid), 64'd0);
    check("x_rst_m_ready", 64'(bus2.m_ready), 64'd0);
    check("x_rst_req_addr", 64'(bus2.req_addr), 64'd0);
    check("x_rst_req_write", 64'(bus2.req_write), 64'd0);
    @(negedge clk);
    check("x_held_m_ready", 64'(bus2.m_ready), 64'd0);
    bus2.m_valid = 2'b11;
    rst = 1'b0;
    @(negedge clk);
    check("x_after_req_valid", 64'(bus2.req_valid), 64'd1);
    check("x_after_grant_id", 64'(bus2.grant_id), 64'd0);
    check("x_after_req_addr", 64'(bus2.req_addr), 64'h3000_0000);
    bus2.req_ready = 1'b1;
    @(negedge clk);
    bus2.req_ready = 1'b0;
    bus2.m_valid = 2'b00;
    check("x_after_m_ready", 64'(bus2.m_ready), 64'd1);
    @(negedge clk);

    // Four requesters all valid with a zero-wait downstream: 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      xfer4(4'b1111, j % 4);
    end
    // Grant 2, then 2 and 3 arrive together: 3 wins, then 2.
    xfer4(4'b0100, 2);
    xfer4(4'b1100, 3);
    xfer4(4'b0100, 2);
    bus4.m_valid = 4'b0000;
    @(negedge clk);
    check("c_end_req_valid", 64'(bus4.req_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
